// File: rtl/mux_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_bist_pkg
//  Description : Shared types, constants and the data-pattern generator for
//                the mux built-in self-test engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_bist_pkg;

    // Width of the mismatch counter.
    localparam int ERRW = 16;

    // Engine states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // (pat*(2*idx+1) + idx) mod 2^width, computed at 32 bits then masked.
    // The caller truncates the result to its own data width.
    function automatic logic [31:0] pattern_word(input int unsigned pat,
                                                 input int unsigned idx,
                                                 input int unsigned width);
        logic [31:0] full;
        logic [31:0] mask;
        full = 32'(pat * (2 * idx + 1) + idx);
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return full & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux2_gate.sv
`default_nettype none
// ============================================================================
//  Module      : mux2_gate
//  Description : W-bit 2:1 multiplexer built from not/and/or primitives.
//                z = s ? b : a
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2_gate #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output wire  [WIDTH-1:0] z
);

    wire w_s_n;

    not u_not_s (w_s_n, s);

    // One and-or pair per data bit; the inverted select is shared.
    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        wire w_a_term;
        wire w_b_term;
        and u_and_a (w_a_term, a[k], w_s_n);
        and u_and_b (w_b_term, b[k], s);
        or  u_or_z  (z[k], w_a_term, w_b_term);
    end

endmodule
`default_nettype wire

// File: rtl/mux_bist.sv
`default_nettype none
// ============================================================================
//  Module      : mux_bist
//  Description : N-channel W-bit gate-level mux tree with a clocked
//                self-test engine that sweeps every select value against a
//                set of deterministic data patterns and reports the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_bist
    import mux_bist_pkg::*;
#(
    parameter int  WIDTH    = 4,
    parameter int  CHANNELS = 4,
    parameter int  PATTERNS = 16,
    localparam int SELW     = $clog2(CHANNELS),
    localparam int PATW     = $clog2(PATTERNS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            fault_inj,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_count,
    output logic            fail_valid,
    output logic [SELW-1:0] first_fail_sel,
    output logic [PATW-1:0] first_fail_pat
);

    state_t           r_state;
    state_t           w_state_next;
    logic [SELW-1:0]  r_sel;
    logic [PATW-1:0]  r_pat;
    logic [WIDTH-1:0] r_mux_q;
    logic [ERRW-1:0]  r_err_count;
    logic             r_fail_valid;
    logic [SELW-1:0]  r_first_sel;
    logic [PATW-1:0]  r_first_pat;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_data [CHANNELS];
    logic [WIDTH-1:0] w_mux_out;
    logic [WIDTH-1:0] w_expected;
    logic [WIDTH-1:0] w_observed;
    logic             w_mismatch;
    logic             w_last_vec;
    logic             w_launch;

    // Channel stimulus for the current pattern index.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_data[i] = WIDTH'(pattern_word(32'(r_pat), i, WIDTH));
        end
    end

    // Mux tree: level 0 is the root, level SELW-1 reads the channel data.
    // Level l has 2^l nodes and is steered by sel bit SELW-1-l, so sel's
    // LSB picks between adjacent channels at the leaves.
    for (genvar l = 0; l < SELW; l++) begin : g_lvl
        wire [WIDTH-1:0] w_out [2**l];
        for (genvar j = 0; j < 2**l; j++) begin : g_node
            if (l == SELW - 1) begin : g_leaf
                mux2_gate #(.WIDTH(WIDTH)) u_mux (
                    .a (w_data[2*j]),
                    .b (w_data[2*j+1]),
                    .s (r_sel[SELW-1-l]),
                    .z (w_out[j])
                );
            end else begin : g_inner
                mux2_gate #(.WIDTH(WIDTH)) u_mux (
                    .a (g_lvl[l+1].w_out[2*j]),
                    .b (g_lvl[l+1].w_out[2*j+1]),
                    .s (r_sel[SELW-1-l]),
                    .z (w_out[j])
                );
            end
        end
    end

    assign w_mux_out = g_lvl[0].w_out[0];

    // Reference value computed directly from the indices, not via the tree.
    assign w_expected = WIDTH'(pattern_word(32'(r_pat), 32'(r_sel), WIDTH));
    assign w_observed = r_mux_q ^ WIDTH'(fault_inj);
    assign w_mismatch = (w_observed != w_expected);
    assign w_last_vec = (&r_sel) && (&r_pat);
    assign w_launch   = ((r_state == IDLE) || (r_state == DONE)) && start;

    // State register plus registered status flags decoded from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == APPLY) || (w_state_next == CHECK);
            r_done  <= (w_state_next == DONE);
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = APPLY;
            APPLY:   w_state_next = CHECK;
            CHECK:   w_state_next = w_last_vec ? DONE : APPLY;
            DONE:    if (start) w_state_next = APPLY;
            default: w_state_next = IDLE;
        endcase
    end

    // Sweep indices, captured mux output, mismatch counter and first-fail log.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel        <= '0;
            r_pat        <= '0;
            r_mux_q      <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_first_sel  <= '0;
            r_first_pat  <= '0;
        end else begin
            if (w_launch) begin
                r_sel        <= '0;
                r_pat        <= '0;
                r_err_count  <= '0;
                r_fail_valid <= 1'b0;
                r_first_sel  <= '0;
                r_first_pat  <= '0;
            end
            if (r_state == APPLY) begin
                r_mux_q <= w_mux_out;
            end
            if (r_state == CHECK) begin
                if (w_mismatch) begin
                    if (r_err_count != '1) begin
                        r_err_count <= r_err_count + 1'b1;
                    end
                    if (!r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_first_sel  <= r_sel;
                        r_first_pat  <= r_pat;
                    end
                end
                if (!w_last_vec) begin
                    r_pat <= r_pat + 1'b1;
                    if (&r_pat) begin
                        r_sel <= r_sel + 1'b1;
                    end
                end
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_done && (r_err_count == '0);
    assign err_count      = r_err_count;
    assign fail_valid     = r_fail_valid;
    assign first_fail_sel = r_first_sel;
    assign first_fail_pat = r_first_pat;

endmodule
`default_nettype wire

// File: tb/tb_mux_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_bist
//  Description : Self-checking bench for mux_bist (default build and an
//                8-bit / 8-channel / 4-pattern build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_bist;
    import mux_bist_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        fault_inj;
    logic        busy, done, pass, fail_valid;
    logic [15:0] err_count;
    logic [1:0]  first_fail_sel;
    logic [3:0]  first_fail_pat;

    logic        start8;
    logic        fault8;
    logic        busy8, done8, pass8, fv8;
    logic [15:0] err8;
    logic [2:0]  fsel8;
    logic [1:0]  fpat8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          lat;
        int          busy_cyc;
        logic [15:0] err;
        logic        fv;
        logic [1:0]  fsel;
        logic [3:0]  fpat;
        logic        pass;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq_sb[$];

    always #5 clk = ~clk;

    mux_bist dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .fault_inj      (fault_inj),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .fail_valid     (fail_valid),
        .first_fail_sel (first_fail_sel),
        .first_fail_pat (first_fail_pat)
    );

    mux_bist #(.WIDTH(8), .CHANNELS(8), .PATTERNS(4)) dut8 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start8),
        .fault_inj      (fault8),
        .busy           (busy8),
        .done           (done8),
        .pass           (pass8),
        .err_count      (err8),
        .fail_valid     (fv8),
        .first_fail_sel (fsel8),
        .first_fail_pat (fpat8)
    );

    // Pulse start on the default DUT, then count edges until done.
    // lat is the number of edges after the start edge at which done is seen
    // (-1 if it never appears). Optional fault pulse and ignored start pulse.
    task automatic run_sweep(input int target_e, input int ign_e,
                             output int lat, output int busy_cyc,
                             output logic [15:0] err0, output logic fv0,
                             output logic busy0);
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = -1;
        busy_cyc = 0;
        err0     = err_count;
        fv0      = fail_valid;
        busy0    = busy;
        for (int e = 0; e < 1000; e++) begin
            if (done) begin
                lat = e;
                break;
            end
            if (busy) busy_cyc++;
            if (target_e >= 0 && e == target_e)     fault_inj = 1'b1;
            if (target_e >= 0 && e == target_e + 1) fault_inj = 1'b0;
            start = (ign_e >= 0 && e == ign_e);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // Pop one scoreboard entry and compare it with the final DUT status.
    task automatic compare_result(input string name, input int lat, input int busy_cyc);
        exp_t ex;
        ex = sb.pop_front();
        checks++; if (lat !== ex.lat) begin failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, ex.lat); end
        checks++; if (busy_cyc !== ex.busy_cyc) begin failures++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cyc, ex.busy_cyc); end
        checks++; if (err_count !== ex.err) begin failures++;
            $display("FAIL %s err_count: got %0d expected %0d", name, err_count, ex.err); end
        checks++; if (fail_valid !== ex.fv) begin failures++;
            $display("FAIL %s fail_valid: got %0d expected %0d", name, fail_valid, ex.fv); end
        checks++; if (first_fail_sel !== ex.fsel || first_fail_pat !== ex.fpat) begin failures++;
            $display("FAIL %s first_fail: got (%0d,%0d) expected (%0d,%0d)", name,
                     first_fail_sel, first_fail_pat, ex.fsel, ex.fpat); end
        checks++; if (pass !== ex.pass) begin failures++;
            $display("FAIL %s pass: got %0d expected %0d", name, pass, ex.pass); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({busy, done, pass, fail_valid} !== 4'b0000) begin failures++;
            $display("FAIL reset flags: got %b expected 0000", {busy, done, pass, fail_valid}); end
        checks++; if (err_count !== 16'd0) begin failures++;
            $display("FAIL reset err_count: got %0d expected 0", err_count); end
        checks++; if (first_fail_sel !== 2'd0 || first_fail_pat !== 4'd0) begin failures++;
            $display("FAIL reset first_fail: got (%0d,%0d) expected (0,0)", first_fail_sel, first_fail_pat); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clean();
        int lat, bc; logic [15:0] e0; logic f0, b0;
        sb.push_back('{lat: 128, busy_cyc: 128, err: 16'd0, fv: 1'b0, fsel: 2'd0, fpat: 4'd0, pass: 1'b1});
        run_sweep(-1, -1, lat, bc, e0, f0, b0);
        checks++; if (b0 !== 1'b1) begin failures++;
            $display("FAIL clean busy_after_start: got %0d expected 1", b0); end
        compare_result("clean", lat, bc);
        // DONE holds its results; fault_inj outside CHECK must not disturb them.
        fault_inj = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fault_inj = 1'b0;
        checks++; if (done !== 1'b1 || pass !== 1'b1 || err_count !== 16'd0) begin failures++;
            $display("FAIL clean hold: got done=%0d pass=%0d err=%0d expected 1 1 0", done, pass, err_count); end
    endtask

    task automatic test_stuck();
        int lat, bc; logic [15:0] e0; logic f0, b0;
        fault_inj = 1'b1;
        sb.push_back('{lat: 128, busy_cyc: 128, err: 16'd64, fv: 1'b1, fsel: 2'd0, fpat: 4'd0, pass: 1'b0});
        run_sweep(-1, -1, lat, bc, e0, f0, b0);
        fault_inj = 1'b0;
        compare_result("stuck", lat, bc);
    endtask

    // Starts from DONE with err_count=64 left by the stuck run.
    task automatic test_ignore_restart();
        int lat, bc; logic [15:0] e0; logic f0, b0;
        sb.push_back('{lat: 128, busy_cyc: 128, err: 16'd0, fv: 1'b0, fsel: 2'd0, fpat: 4'd0, pass: 1'b1});
        run_sweep(-1, 10, lat, bc, e0, f0, b0);
        checks++; if (e0 !== 16'd0 || f0 !== 1'b0) begin failures++;
            $display("FAIL restart clear: got err=%0d fv=%0d expected 0 0", e0, f0); end
        compare_result("ignore_restart", lat, bc);
    endtask

    // Fault asserted only across the CHECK of vector (sel=2,pat=5), index 37.
    task automatic test_targeted();
        int lat, bc; logic [15:0] e0; logic f0, b0;
        sb.push_back('{lat: 128, busy_cyc: 128, err: 16'd1, fv: 1'b1, fsel: 2'd2, fpat: 4'd5, pass: 1'b0});
        run_sweep(2 * (2 * 16 + 5) + 1, -1, lat, bc, e0, f0, b0);
        compare_result("targeted", lat, bc);
    endtask

    task automatic test_reset_mid();
        int lat, bc; logic [15:0] e0; logic f0, b0;
        fault_inj = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        fault_inj = 1'b0;
        checks++; if ({busy, done, pass, fail_valid} !== 4'b0000 || err_count !== 16'd0) begin failures++;
            $display("FAIL mid_reset outputs: got flags=%b err=%0d expected 0000 0",
                     {busy, done, pass, fail_valid}, err_count); end
        checks++; if (dut.r_state !== IDLE) begin failures++;
            $display("FAIL mid_reset state: got %0d expected %0d", dut.r_state, IDLE); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{lat: 128, busy_cyc: 128, err: 16'd0, fv: 1'b0, fsel: 2'd0, fpat: 4'd0, pass: 1'b1});
        run_sweep(-1, -1, lat, bc, e0, f0, b0);
        compare_result("after_mid_reset", lat, bc);
    endtask

    // Wide build: every captured mux_q is compared in sweep order.
    task automatic test_wide();
        int   lat;
        logic [7:0] exp_q;
        logic [31:0] pw;
        for (int s = 0; s < 8; s++) begin
            for (int p = 0; p < 4; p++) begin
                pw = pattern_word(p, s, 8);
                mq_sb.push_back(pw[7:0]);
            end
        end
        lat = -1;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int e = 0; e < 500; e++) begin
            if (done8) begin
                lat = e;
                break;
            end
            if (dut8.r_state == CHECK) begin
                exp_q = mq_sb.pop_front();
                checks++; if (dut8.r_mux_q !== exp_q) begin failures++;
                    $display("FAIL wide mux_q sel=%0d pat=%0d: got %0d expected %0d",
                             dut8.r_sel, dut8.r_pat, dut8.r_mux_q, exp_q); end
                if (dut8.r_sel == 3'd7 && dut8.r_pat == 2'd3) begin
                    checks++; if (dut8.r_mux_q !== 8'd52) begin failures++;
                        $display("FAIL wide spot mux_q: got %0d expected 52", dut8.r_mux_q); end
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (lat !== 64) begin failures++;
            $display("FAIL wide latency: got %0d expected 64", lat); end
        checks++; if (pass8 !== 1'b1 || err8 !== 16'd0 || fv8 !== 1'b0) begin failures++;
            $display("FAIL wide result: got pass=%0d err=%0d fv=%0d expected 1 0 0", pass8, err8, fv8); end
        checks++; if (mq_sb.size() !== 0) begin failures++;
            $display("FAIL wide vectors_left: got %0d expected 0", mq_sb.size()); end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        fault_inj = 1'b0;
        start8    = 1'b0;
        fault8    = 1'b0;
        test_reset();
        test_clean();
        test_stuck();
        test_ignore_restart();
        test_targeted();
        test_reset_mid();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
